// File: rtl/mbox_axi_wr_bridge.sv
// mbox_axi_wr_bridge: serialises AXI4 write bursts into single-word AXI-Lite writes
// on one of two 32-bit mailbox ports and merges the Lite responses into one B.
module mbox_axi_wr_bridge #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_ID_WIDTH   = 10,
    parameter int AXI_USER_WIDTH = 6,
    parameter int AXI_STRB_WIDTH = AXI_DATA_WIDTH/8,
    parameter int IF_SEL_BIT     = 12
) (
    input  logic                      Clk_CI,
    input  logic                      Rst_RBI,
    input  logic [AXI_ADDR_WIDTH-1:0] AwAddr_DI,
    input  logic                      AwValid_SI,
    output logic                      AwReady_SO,
    input  logic [7:0]                AwLen_SI,
    input  logic [AXI_ID_WIDTH-1:0]   AwId_DI,
    input  logic [AXI_DATA_WIDTH-1:0] WData_DI,
    input  logic [AXI_STRB_WIDTH-1:0] WStrb_DI,
    input  logic                      WValid_SI,
    output logic                      WReady_SO,
    output logic                      BValid_SO,
    input  logic                      BReady_SI,
    output logic [AXI_ID_WIDTH-1:0]   BId_DO,
    output logic [1:0]                BResp_DO,
    output logic [AXI_USER_WIDTH-1:0] BUser_DO,
    output logic [AXI_ADDR_WIDTH-1:0] If0_AwAddr_DO,
    output logic                      If0_AwValid_SO,
    input  logic                      If0_AwReady_SI,
    output logic [31:0]               If0_WData_DO,
    output logic [3:0]                If0_WStrb_DO,
    output logic                      If0_WValid_SO,
    input  logic                      If0_WReady_SI,
    input  logic                      If0_BValid_SI,
    output logic                      If0_BReady_SO,
    input  logic [1:0]                If0_BResp_DI,
    output logic [AXI_ADDR_WIDTH-1:0] If1_AwAddr_DO,
    output logic                      If1_AwValid_SO,
    input  logic                      If1_AwReady_SI,
    output logic [31:0]               If1_WData_DO,
    output logic [3:0]                If1_WStrb_DO,
    output logic                      If1_WValid_SO,
    input  logic                      If1_WReady_SI,
    input  logic                      If1_BValid_SI,
    output logic                      If1_BReady_SO,
    input  logic [1:0]                If1_BResp_DI
);
    localparam int NL = AXI_DATA_WIDTH/32;
    localparam int SB = $clog2(AXI_STRB_WIDTH);
    typedef enum logic [2:0] {IDLE, W_ACC, LITE_REQ, LITE_RSP, B_RSP} state_e;
    state_e                     state_q, state_d;
    logic                       init_q;
    logic [AXI_ADDR_WIDTH-SB-1:0] addr_q, addr_d;
    logic [AXI_ID_WIDTH-1:0]    id_q, id_d;
    logic [7:0]                 len_q, len_d, cnt_q, cnt_d;
    logic [1:0]                 resp_q, resp_d;
    logic                       sel_q, sel_d;
    logic [AXI_ADDR_WIDTH-1:0]  laddr_q, laddr_d;
    logic [31:0]                ldata_q, ldata_d;
    logic [3:0]                 lstrb_q, lstrb_d;
    logic                       aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic [31:0]                pick_data;
    logic [3:0]                 pick_strb;
    logic [AXI_ADDR_WIDTH-1:0]  lane_off;
    logic                       req_aw, req_w, rsp, lite_aw_hs, lite_w_hs, lite_b_hs, last;
    logic [1:0]                 lite_bresp;
    // Lowest lane with any strobe wins; higher lanes of the beat are discarded.
    always_comb begin
        pick_data = '0;
        pick_strb = '0;
        lane_off  = '0;
        for (int k = NL-1; k >= 0; k--) begin
            if (|WStrb_DI[4*k +: 4]) begin
                pick_data = WData_DI[32*k +: 32];
                pick_strb = WStrb_DI[4*k +: 4];
                lane_off  = AXI_ADDR_WIDTH'(4*k);
            end
        end
    end
    assign req_aw     = (state_q == LITE_REQ) & ~aw_done_q;
    assign req_w      = (state_q == LITE_REQ) & ~w_done_q;
    assign rsp        = state_q == LITE_RSP;
    assign lite_aw_hs = req_aw & (sel_q ? If1_AwReady_SI : If0_AwReady_SI);
    assign lite_w_hs  = req_w & (sel_q ? If1_WReady_SI : If0_WReady_SI);
    assign lite_b_hs  = rsp & (sel_q ? If1_BValid_SI : If0_BValid_SI);
    assign lite_bresp = sel_q ? If1_BResp_DI : If0_BResp_DI;
    assign last       = cnt_q == len_q;
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        id_d      = id_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        resp_d    = resp_q;
        sel_d     = sel_q;
        laddr_d   = laddr_q;
        ldata_d   = ldata_q;
        lstrb_d   = lstrb_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        case (state_q)
            IDLE: if (AwValid_SI & init_q) begin
                addr_d  = AwAddr_DI[AXI_ADDR_WIDTH-1:SB];
                id_d    = AwId_DI;
                len_d   = AwLen_SI;
                cnt_d   = '0;
                resp_d  = 2'b00;
                sel_d   = AwAddr_DI[IF_SEL_BIT];
                state_d = W_ACC;
            end
            W_ACC: if (WValid_SI) begin
                if (|WStrb_DI) begin
                    laddr_d = {addr_q, SB'(0)} | lane_off;
                    ldata_d = pick_data;
                    lstrb_d = pick_strb;
                    state_d = LITE_REQ;
                end else if (last) state_d = B_RSP;
                else cnt_d = cnt_q + 8'd1;
            end
            LITE_REQ: begin
                aw_done_d = aw_done_q | lite_aw_hs;
                w_done_d  = w_done_q | lite_w_hs;
                if (aw_done_d & w_done_d) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = LITE_RSP;
                end
            end
            LITE_RSP: if (lite_b_hs) begin
                resp_d  = (lite_bresp > resp_q) ? lite_bresp : resp_q;
                state_d = last ? B_RSP : W_ACC;
                cnt_d   = last ? cnt_q : cnt_q + 8'd1;
            end
            B_RSP: if (BReady_SI) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            state_q   <= IDLE;
            init_q    <= 1'b0;
            addr_q    <= '0;
            id_q      <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            resp_q    <= '0;
            sel_q     <= 1'b0;
            laddr_q   <= '0;
            ldata_q   <= '0;
            lstrb_q   <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            init_q    <= 1'b1;
            addr_q    <= addr_d;
            id_q      <= id_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            resp_q    <= resp_d;
            sel_q     <= sel_d;
            laddr_q   <= laddr_d;
            ldata_q   <= ldata_d;
            lstrb_q   <= lstrb_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end
    // init_q keeps AwReady low while reset is held, even though state_q is IDLE.
    assign AwReady_SO     = init_q & (state_q == IDLE);
    assign WReady_SO      = state_q == W_ACC;
    assign BValid_SO      = state_q == B_RSP;
    assign BId_DO         = id_q;
    assign BResp_DO       = resp_q;
    assign BUser_DO       = '0;
    assign If0_AwAddr_DO  = sel_q ? '0 : laddr_q;
    assign If0_AwValid_SO = req_aw & ~sel_q;
    assign If0_WData_DO   = sel_q ? '0 : ldata_q;
    assign If0_WStrb_DO   = sel_q ? '0 : lstrb_q;
    assign If0_WValid_SO  = req_w & ~sel_q;
    assign If0_BReady_SO  = rsp & ~sel_q;
    assign If1_AwAddr_DO  = sel_q ? laddr_q : '0;
    assign If1_AwValid_SO = req_aw & sel_q;
    assign If1_WData_DO   = sel_q ? ldata_q : '0;
    assign If1_WStrb_DO   = sel_q ? lstrb_q : '0;
    assign If1_WValid_SO  = req_w & sel_q;
    assign If1_BReady_SO  = rsp & sel_q;
endmodule

// File: tb/tb_mbox_axi_wr_bridge.sv
// tb_mbox_axi_wr_bridge: directed vector table for single writes plus hand-written
// burst, back-pressure and mid-transaction reset sequences.
module tb_mbox_axi_wr_bridge;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic [31:0] aw_addr = '0;
    logic        aw_valid = 1'b0, w_valid = 1'b0, b_ready = 1'b0;
    logic [7:0]  aw_len = '0, w_strb = '0;
    logic [9:0]  aw_id = '0;
    logic [63:0] w_data = '0;
    logic        aw_ready, w_ready, b_valid;
    logic [9:0]  b_id;
    logic [1:0]  b_resp;
    logic [5:0]  b_user;
    logic [31:0] l0_awaddr, l1_awaddr, l0_wdata, l1_wdata;
    logic [3:0]  l0_wstrb, l1_wstrb;
    logic        l0_awv, l1_awv, l0_wv, l1_wv, l0_bready, l1_bready;
    logic [1:0]  aw_rdy = 2'b11, w_rdy = 2'b11, l_bv, l_resp;
    logic [1:0]  resp_seq [0:1023];
    int          awc0, awc1, wc0, wc1, bc0, bc1, btot, v0, v1, cyc;
    logic [31:0] la0, la1, ld0, ld1;
    logic [3:0]  ls0, ls1;
    logic [63:0] beat_data [0:255];
    logic [7:0]  beat_strb [0:255];
    int          checks = 0, errors = 0;
    int          aw_c, b_c, s_aw0, s_aw1, s_w0, s_w1, s_v0, s_v1, awv_n, wv_n, stab_err;
    logic [9:0]  got_id;
    logic [1:0]  got_resp;
    logic [5:0]  got_user;

    typedef struct {
        logic [31:0] addr;
        logic [9:0]  id;
        logic [63:0] data;
        logic [7:0]  strb;
        logic [1:0]  lresp;
        logic        sel;
        logic [31:0] laddr;
        logic [31:0] ldata;
        logic [3:0]  lstrb;
        logic [1:0]  bresp;
    } vec_t;
    vec_t vecs [6];

    mbox_axi_wr_bridge dut (
        .Clk_CI(clk), .Rst_RBI(rst_n),
        .AwAddr_DI(aw_addr), .AwValid_SI(aw_valid), .AwReady_SO(aw_ready), .AwLen_SI(aw_len), .AwId_DI(aw_id),
        .WData_DI(w_data), .WStrb_DI(w_strb), .WValid_SI(w_valid), .WReady_SO(w_ready),
        .BValid_SO(b_valid), .BReady_SI(b_ready), .BId_DO(b_id), .BResp_DO(b_resp), .BUser_DO(b_user),
        .If0_AwAddr_DO(l0_awaddr), .If0_AwValid_SO(l0_awv), .If0_AwReady_SI(aw_rdy[0]),
        .If0_WData_DO(l0_wdata), .If0_WStrb_DO(l0_wstrb), .If0_WValid_SO(l0_wv), .If0_WReady_SI(w_rdy[0]),
        .If0_BValid_SI(l_bv[0]), .If0_BReady_SO(l0_bready), .If0_BResp_DI(l_resp),
        .If1_AwAddr_DO(l1_awaddr), .If1_AwValid_SO(l1_awv), .If1_AwReady_SI(aw_rdy[1]),
        .If1_WData_DO(l1_wdata), .If1_WStrb_DO(l1_wstrb), .If1_WValid_SO(l1_wv), .If1_WReady_SI(w_rdy[1]),
        .If1_BValid_SI(l_bv[1]), .If1_BReady_SO(l1_bready), .If1_BResp_DI(l_resp)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Lite slave model: one B per completed AW+W pair, response taken from resp_seq.
    assign l_bv[0] = (awc0 > bc0) && (wc0 > bc0);
    assign l_bv[1] = (awc1 > bc1) && (wc1 > bc1);
    assign l_resp  = resp_seq[btot[9:0]];
    always @(posedge clk) if (rst_n) begin
        if (l0_awv && aw_rdy[0]) begin awc0 <= awc0 + 1; la0 <= l0_awaddr; end
        if (l0_wv && w_rdy[0]) begin wc0 <= wc0 + 1; ld0 <= l0_wdata; ls0 <= l0_wstrb; end
        if (l_bv[0] && l0_bready) begin bc0 <= bc0 + 1; btot <= btot + 1; end
        if (l1_awv && aw_rdy[1]) begin awc1 <= awc1 + 1; la1 <= l1_awaddr; end
        if (l1_wv && w_rdy[1]) begin wc1 <= wc1 + 1; ld1 <= l1_wdata; ls1 <= l1_wstrb; end
        if (l_bv[1] && l1_bready) begin bc1 <= bc1 + 1; btot <= btot + 1; end
        if (l0_awv || l0_wv) v0 <= v0 + 1;
        if (l1_awv || l1_wv) v1 <= v1 + 1;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic snap();
        s_aw0 = awc0; s_aw1 = awc1; s_w0 = wc0; s_w1 = wc1; s_v0 = v0; s_v1 = v1;
    endtask

    task automatic wait_hi(input string nm, ref logic sig);
        int n = 0;
        while (!sig && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) chk({nm, "_timeout"}, 64'(n), 64'd0);
    endtask

    task automatic axi_write(input logic [31:0] a, input logic [9:0] id, input logic [7:0] len);
        @(negedge clk);
        aw_addr = a; aw_id = id; aw_len = len; aw_valid = 1'b1;
        wait_hi("aw", aw_ready);
        aw_c = cyc;
        @(negedge clk);
        aw_valid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            w_data = beat_data[i]; w_strb = beat_strb[i]; w_valid = 1'b1;
            wait_hi("w", w_ready);
            @(negedge clk);
        end
        w_valid = 1'b0; b_ready = 1'b1;
        wait_hi("b", b_valid);
        b_c = cyc; got_id = b_id; got_resp = b_resp; got_user = b_user;
        @(negedge clk);
        b_ready = 1'b0;
    endtask

    initial begin
        vecs[0] = '{32'h0000_0004, 10'h155, 64'hDEADBEEF_00000000, 8'hF0, 2'd0, 1'b0, 32'h0000_0004, 32'hDEADBEEF, 4'hF, 2'd0};
        vecs[1] = '{32'h0000_1000, 10'h003, 64'h11111111_22222222, 8'h0F, 2'd0, 1'b1, 32'h0000_1000, 32'h22222222, 4'hF, 2'd0};
        vecs[2] = '{32'h0000_1008, 10'h2AA, 64'hCAFEF00D_12345678, 8'h30, 2'd2, 1'b1, 32'h0000_100C, 32'hCAFEF00D, 4'h3, 2'd2};
        vecs[3] = '{32'h0000_0020, 10'h001, 64'hAAAA5555_01020304, 8'h11, 2'd1, 1'b0, 32'h0000_0020, 32'h01020304, 4'h1, 2'd1};
        vecs[4] = '{32'h0000_0FFC, 10'h3FF, 64'h87654321_00000000, 8'hC0, 2'd3, 1'b0, 32'h0000_0FFC, 32'h87654321, 4'hC, 2'd3};
        vecs[5] = '{32'hFFFF_F000, 10'h0F0, 64'h0BADCAFE_FFFFFFFF, 8'h80, 2'd0, 1'b1, 32'hFFFF_F004, 32'h0BADCAFE, 4'h8, 2'd0};
        for (int i = 0; i < 1024; i++) resp_seq[i] = 2'd0;

        repeat (3) @(negedge clk);
        chk("rst_outputs", 64'(|{aw_ready, w_ready, b_valid, b_id, b_resp, b_user, l0_awaddr, l0_awv, l0_wdata,
            l0_wstrb, l0_wv, l0_bready, l1_awaddr, l1_awv, l1_wdata, l1_wstrb, l1_wv, l1_bready}), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("awready_after_rst", 64'(aw_ready), 64'd1);
        chk("wready_idle", 64'(w_ready), 64'd0);

        foreach (vecs[i]) begin
            beat_data[0] = vecs[i].data; beat_strb[0] = vecs[i].strb;
            resp_seq[btot] = vecs[i].lresp;
            snap();
            axi_write(vecs[i].addr, vecs[i].id, 8'd0);
            chk($sformatf("v%0d_bid", i), 64'(got_id), 64'(vecs[i].id));
            chk($sformatf("v%0d_bresp", i), 64'(got_resp), 64'(vecs[i].bresp));
            chk($sformatf("v%0d_buser", i), 64'(got_user), 64'd0);
            chk($sformatf("v%0d_latency", i), 64'(b_c - aw_c), 64'd4);
            chk($sformatf("v%0d_aw_count", i), 64'(vecs[i].sel ? awc1 - s_aw1 : awc0 - s_aw0), 64'd1);
            chk($sformatf("v%0d_w_count", i), 64'(vecs[i].sel ? wc1 - s_w1 : wc0 - s_w0), 64'd1);
            chk($sformatf("v%0d_other_if_quiet", i), 64'(vecs[i].sel ? v0 - s_v0 : v1 - s_v1), 64'd0);
            chk($sformatf("v%0d_laddr", i), 64'(vecs[i].sel ? la1 : la0), 64'(vecs[i].laddr));
            chk($sformatf("v%0d_ldata", i), 64'(vecs[i].sel ? ld1 : ld0), 64'(vecs[i].ldata));
            chk($sformatf("v%0d_lstrb", i), 64'(vecs[i].sel ? ls1 : ls0), 64'(vecs[i].lstrb));
        end

        // len=1 burst whose second beat carries no strobes
        beat_data[0] = 64'h99999999_13572468; beat_strb[0] = 8'h0F;
        beat_data[1] = 64'h77777777_66666666; beat_strb[1] = 8'h00;
        snap();
        axi_write(32'h0000_0040, 10'h042, 8'd1);
        chk("len1_writes", 64'(awc0 - s_aw0), 64'd1);
        chk("len1_ldata", 64'(ld0), 64'h13572468);
        chk("len1_bid", 64'(got_id), 64'h042);
        chk("len1_bresp", 64'(got_resp), 64'd0);

        // len=2 burst, worst Lite response wins
        beat_data[0] = 64'h0; beat_strb[0] = 8'hFF;
        beat_data[1] = 64'hABCD0001_00000000; beat_strb[1] = 8'hF0;
        beat_data[2] = 64'h0000FFFF_5A5A5A5A; beat_strb[2] = 8'h0F;
        resp_seq[btot] = 2'd0; resp_seq[btot+1] = 2'd2; resp_seq[btot+2] = 2'd0;
        snap();
        axi_write(32'h0000_0080, 10'h100, 8'd2);
        chk("len2_writes", 64'(awc0 - s_aw0), 64'd3);
        chk("len2_bresp", 64'(got_resp), 64'd2);
        chk("len2_last_laddr", 64'(la0), 64'h80);
        chk("len2_last_ldata", 64'(ld0), 64'h5A5A5A5A);

        // Lite AW ready delayed three cycles, W ready delayed one
        beat_data[0] = 64'h55667788_11223344; beat_strb[0] = 8'hF0;
        resp_seq[btot] = 2'd0;
        aw_rdy[0] = 1'b0; w_rdy[0] = 1'b0;
        awv_n = 0; wv_n = 0; stab_err = 0;
        snap();
        fork
            axi_write(32'h0000_0008, 10'h0AB, 8'd0);
            begin
                wait_hi("lite_req", l0_awv);
                for (int c = 0; c < 6; c++) begin
                    w_rdy[0] = (c == 1); aw_rdy[0] = (c == 3);
                    if (l0_awv) begin awv_n++; if (l0_awaddr !== 32'hC) stab_err++; end
                    if (l0_wv) begin wv_n++; if (l0_wdata !== 32'h55667788 || l0_wstrb !== 4'hF) stab_err++; end
                    @(negedge clk);
                end
                aw_rdy[0] = 1'b1; w_rdy[0] = 1'b1;
            end
        join
        chk("bp_awvalid_cycles", 64'(awv_n), 64'd4);
        chk("bp_wvalid_cycles", 64'(wv_n), 64'd2);
        chk("bp_stable", 64'(stab_err), 64'd0);
        chk("bp_writes", 64'(awc0 - s_aw0), 64'd1);
        chk("bp_bid", 64'(got_id), 64'h0AB);

        // reset pulsed while a Lite request is outstanding
        aw_rdy[0] = 1'b0; w_rdy[0] = 1'b0;
        @(negedge clk);
        aw_addr = 32'h10; aw_len = 8'd0; aw_id = 10'h005; aw_valid = 1'b1;
        @(negedge clk);
        aw_valid = 1'b0; w_data = 64'h1; w_strb = 8'h0F; w_valid = 1'b1;
        @(negedge clk);
        w_valid = 1'b0;
        chk("rst_pre_req", 64'(l0_awv), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_outputs", 64'(|{aw_ready, w_ready, b_valid, b_id, b_resp, b_user, l0_awaddr, l0_awv, l0_wdata,
            l0_wstrb, l0_wv, l0_bready, l1_awaddr, l1_awv, l1_wdata, l1_wstrb, l1_wv, l1_bready}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1; aw_rdy = 2'b11; w_rdy = 2'b11;
        beat_data[0] = 64'h0F0F0F0F_24682468; beat_strb[0] = 8'h0F;
        resp_seq[btot] = 2'd0;
        snap();
        axi_write(32'h0000_0010, 10'h006, 8'd0);
        chk("post_rst_writes", 64'(awc0 - s_aw0), 64'd1);
        chk("post_rst_ldata", 64'(ld0), 64'h24682468);
        chk("post_rst_bid", 64'(got_id), 64'h006);
        chk("post_rst_latency", 64'(b_c - aw_c), 64'd4);

        // len=255: exactly 256 beats, one DECERR among them
        for (int i = 0; i < 256; i++) begin
            beat_data[i] = {32'hF00D0000 + 32'(i), 32'(i)};
            beat_strb[i] = 8'h0F;
            resp_seq[btot + i] = (i == 200) ? 2'd3 : 2'd0;
        end
        snap();
        axi_write(32'h0000_1000, 10'h200, 8'd255);
        chk("len255_writes", 64'(awc1 - s_aw1), 64'd256);
        chk("len255_if0_quiet", 64'(v0 - s_v0), 64'd0);
        chk("len255_bresp", 64'(got_resp), 64'd3);
        chk("len255_last_ldata", 64'(ld1), 64'hFF);
        chk("len255_bid", 64'(got_id), 64'h200);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
